// File: rtl/clk_tick_monitor_if.sv
// rtl/clk_tick_monitor_if.sv - slow-wave input and tick/measurement outputs of clk_tick_monitor
interface clk_tick_monitor_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             slow_in;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             fault;

  modport master (
    output enable, slow_in,
    input  rise_tick, fall_tick, period, period_valid, locked, fault
  );

  modport slave (
    input  enable, slow_in,
    output rise_tick, fall_tick, period, period_valid, locked, fault
  );
endinterface

// File: rtl/clk_tick_monitor.sv
// rtl/clk_tick_monitor.sv - slow-wave edge ticks, period measurement and lock/fault tracking
module clk_tick_monitor #(
  parameter int EXP_PERIOD = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input logic             clk_in,
  input logic             reset,
  clk_tick_monitor_if.slave bus
);
  localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] EXP_C      = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(2 * EXP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [MW-1:0]    LOCK_M1    = MW'(LOCK_COUNT - 1);

  typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, LOCKED, FAULT} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  // FAULT is taken on the edge where cnt would reach twice the expected period
  assign timeout = (cnt >= TIMEOUT_M1);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1               <= 1'b0;
      s2               <= 1'b0;
      s3               <= 1'b0;
      state            <= IDLE;
      cnt              <= '0;
      match            <= '0;
      bus.rise_tick    <= 1'b0;
      bus.fall_tick    <= 1'b0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
      bus.locked       <= 1'b0;
      bus.fault        <= 1'b0;
    end else begin
      s1               <= bus.slow_in;
      s2               <= s1;
      s3               <= s2;
      bus.rise_tick    <= rise;
      bus.fall_tick    <= fall;
      bus.period_valid <= 1'b0;

      if (!bus.enable) begin
        state      <= IDLE;
        cnt        <= '0;
        match      <= '0;
        bus.locked <= 1'b0;
        bus.fault  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQUIRE;
            cnt   <= '0;
          end
          ACQUIRE: begin
            if (rise) begin
              state <= MEASURE;
              cnt   <= CNT_W'(1);
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEASURE: begin
            if (rise) begin
              cnt              <= CNT_W'(1);
              bus.period       <= cnt;
              bus.period_valid <= 1'b1;
              if (cnt == EXP_C) begin
                match <= match + 1'b1;
                if (match == LOCK_M1) begin
                  state      <= LOCKED;
                  bus.locked <= 1'b1;
                end
              end else begin
                match <= '0;
              end
            end else begin
              cnt <= cnt_inc;
              if (timeout) begin
                state     <= FAULT;
                bus.fault <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (rise) begin
              cnt              <= CNT_W'(1);
              bus.period       <= cnt;
              bus.period_valid <= 1'b1;
              if (cnt != EXP_C) begin
                state      <= FAULT;
                bus.locked <= 1'b0;
                bus.fault  <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
              if (timeout) begin
                state      <= FAULT;
                bus.locked <= 1'b0;
                bus.fault  <= 1'b1;
              end
            end
          end
          FAULT: begin
            cnt <= cnt_inc;
          end
          default: begin
            state      <= IDLE;
            cnt        <= '0;
            match      <= '0;
            bus.locked <= 1'b0;
            bus.fault  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
